alu_arbiter: RTL and testbench

Two-requester round-robin scheduler that shares one combinational 32-bit ALU (inputs a, b, ALUControl; output result) between independent clients. It accepts operation requests over valid/ready handshakes, drives the shared ALU from registered operands, and returns each result with the requester ID on a single valid/ready response channel. It sits between the issuing units and the ALU instance. The ALU is instantiated outside this block.

---
 rtl/alu_arbiter_if.sv | 50 +++++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals for alu_arbiter.
// slave is the arbiter's view; master is the view of the surrounding requesters, ALU and consumer.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] alu_result;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_id;
  logic             resp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_control,
    input  alu_result,
    output resp_valid, resp_result, resp_id, resp_err,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_control,
    output alu_result,
    input  resp_valid, resp_result, resp_id, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU between two requesters; accept at T, response valid from T+2.
// A stalled response holds RESP and blocks all new grants until resp_ready.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             inflight_id;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_control_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_result_q;
  logic             resp_id_q;
  logic             resp_err_q;

  logic grant0;
  logic grant1;

  function automatic logic op_supported(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: op_supported = 1'b1;
      default:                                op_supported = 1'b0;
    endcase
  endfunction

  // Under contention the requester that did not win last time goes first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_control = alu_control_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_err    = resp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      inflight_id   <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_control_q <= 3'b000;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_id_q     <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_a_q       <= grant1 ? bus.req1_a  : bus.req0_a;
            alu_b_q       <= grant1 ? bus.req1_b  : bus.req0_b;
            alu_control_q <= grant1 ? bus.req1_op : bus.req0_op;
            inflight_id   <= grant1;
            last_grant    <= grant1;
            state         <= EXEC;
          end
        end
        EXEC: begin
          // Unsupported codes return zero regardless of what the ALU drives.
          if (op_supported(alu_control_q)) begin
            resp_result_q <= bus.alu_result;
            resp_err_q    <= 1'b0;
          end else begin
            resp_result_q <= '0;
            resp_err_q    <= 1'b1;
          end
          resp_id_q    <= inflight_id;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (resp_valid_q && bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_one_ready: assert property (@(posedge clk) !(bus.req0_ready && bus.req1_ready));

  a_resp_stable: assert property (@(posedge clk) disable iff (reset)
    (resp_valid_q && !bus.resp_ready) |=>
      (resp_valid_q && $stable(resp_result_q) && $stable(resp_id_q) && $stable(resp_err_q)));

  a_ready_only_idle: assert property (@(posedge clk)
    (bus.req0_ready || bus.req1_ready) |-> (state == IDLE));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single requests plus contention, stall, reset and streaming sequences.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External ALU; unsupported codes drive a junk pattern the arbiter must suppress.
  always_comb begin
    case (bus.alu_control)
      3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b101:  bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      default: bus.alu_result = 32'hDEADBEEF;
    endcase
  end

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp_res;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 3'b000;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 3'b000;
    bus.resp_ready = 1'b0;
  endtask

  task automatic set_req(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  task automatic clr_req(input logic id);
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic expect_ready(input logic r0, input logic r1, input string name);
    #1;
    check({name, "_rdy0"}, {31'b0, bus.req0_ready}, {31'b0, r0});
    check({name, "_rdy1"}, {31'b0, bus.req1_ready}, {31'b0, r1});
  endtask

  // Called at a negedge in RESP; checks the response and raises resp_ready for the next edge.
  task automatic resp_check(input string name, input logic [31:0] res, input logic id, input logic err);
    #1;
    check({name, "_vld"}, {31'b0, bus.resp_valid}, 32'd1);
    check({name, "_res"}, bus.resp_result, res);
    check({name, "_id"},  {31'b0, bus.resp_id},  {31'b0, id});
    check({name, "_err"}, {31'b0, bus.resp_err}, {31'b0, err});
    bus.resp_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rdy0"}, {31'b0, bus.req0_ready}, 32'd0);
    check({name, "_rdy1"}, {31'b0, bus.req1_ready}, 32'd0);
    check({name, "_alu_a"}, bus.alu_a, 32'd0);
    check({name, "_alu_b"}, bus.alu_b, 32'd0);
    check({name, "_alu_ctl"}, {29'b0, bus.alu_control}, 32'd0);
    check({name, "_rvld"}, {31'b0, bus.resp_valid}, 32'd0);
    check({name, "_rres"}, bus.resp_result, 32'd0);
    check({name, "_rid"}, {31'b0, bus.resp_id}, 32'd0);
    check({name, "_rerr"}, {31'b0, bus.resp_err}, 32'd0);
  endtask

  task automatic run_single(input vec_t v);
    int n;
    logic rdy;
    @(negedge clk);
    set_req(v.id, v.a, v.b, v.op);
    bus.resp_ready = 1'b0;
    n = 0;
    #1;
    rdy = v.id ? bus.req1_ready : bus.req0_ready;
    while (!rdy && n < 10) begin
      @(negedge clk); #1;
      rdy = v.id ? bus.req1_ready : bus.req0_ready;
      n++;
    end
    check({v.name, "_acc_wait"}, n, 32'd0);
    check({v.name, "_other_rdy"}, {31'b0, v.id ? bus.req0_ready : bus.req1_ready}, 32'd0);
    @(negedge clk);
    clr_req(v.id);
    #1;
    check({v.name, "_exec_vld"}, {31'b0, bus.resp_valid}, 32'd0);
    check({v.name, "_alu_a"}, bus.alu_a, v.a);
    check({v.name, "_alu_b"}, bus.alu_b, v.b);
    check({v.name, "_alu_ctl"}, {29'b0, bus.alu_control}, {29'b0, v.op});
    @(negedge clk);
    resp_check(v.name, v.exp_res, v.id, v.exp_err);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    check({v.name, "_drop_vld"}, {31'b0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    int t_acc[3];
    int n;

    vecs[0] = '{1'b0, 32'd12,         32'd8,          3'b000, 32'd20,         1'b0, "add"};
    vecs[1] = '{1'b0, 32'd5,          32'd10,         3'b101, 32'd1,          1'b0, "slt_pos"};
    vecs[2] = '{1'b0, 32'hFFFFFFFF,   32'd0,          3'b101, 32'd1,          1'b0, "slt_neg"};
    vecs[3] = '{1'b0, 32'd3,          32'd4,          3'b110, 32'd0,          1'b1, "err110"};
    vecs[4] = '{1'b1, 32'd7,          32'd9,          3'b001, 32'hFFFFFFFE,   1'b0, "sub_wrap"};
    vecs[5] = '{1'b1, 32'hAAAA5555,   32'h12345678,   3'b011, 32'hB89E032D,   1'b0, "xor"};
    vecs[6] = '{1'b0, 32'd1,          32'd2,          3'b100, 32'd0,          1'b1, "err100"};
    vecs[7] = '{1'b1, 32'd1,          32'd2,          3'b111, 32'd0,          1'b1, "err111"};
    vecs[8] = '{1'b1, 32'h80000000,   32'd1,          3'b101, 32'd1,          1'b0, "slt_min"};
    vecs[9] = '{1'b0, 32'd1,          32'h80000000,   3'b101, 32'd0,          1'b0, "slt_false"};

    // Reset with both requests present: no ready may appear while reset is high.
    idle_inputs();
    reset = 1'b1;
    set_req(1'b0, 32'd1, 32'd1, 3'b000);
    set_req(1'b1, 32'd2, 32'd2, 3'b000);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("rst");
    idle_inputs();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_single(vecs[i]);

    // Contention from reset: req0 first, then strict alternation.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_req(1'b0, 32'd20, 32'd5, 3'b001);
    set_req(1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 3'b010);
    expect_ready(1'b1, 1'b0, "cont1");
    @(negedge clk);
    set_req(1'b0, 32'd1, 32'd1, 3'b000);
    expect_ready(1'b0, 1'b0, "cont_exec");
    @(negedge clk);
    resp_check("cont_r1", 32'd15, 1'b0, 1'b0);
    check("cont_resp_rdy0", {31'b0, bus.req0_ready}, 32'd0);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    expect_ready(1'b0, 1'b1, "cont2");
    @(negedge clk);
    set_req(1'b1, 32'd3, 32'd5, 3'b011);
    @(negedge clk);
    resp_check("cont_r2", 32'h00000000, 1'b1, 1'b0);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    expect_ready(1'b1, 1'b0, "cont3");
    @(negedge clk);
    clr_req(1'b0);
    @(negedge clk);
    resp_check("cont_r3", 32'd2, 1'b0, 1'b0);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    expect_ready(1'b0, 1'b1, "cont4");
    @(negedge clk);
    clr_req(1'b1);
    @(negedge clk);
    resp_check("cont_r4", 32'd6, 1'b1, 1'b0);
    @(negedge clk);
    bus.resp_ready = 1'b0;

    // Backpressure: response held for 5 cycles, waiting req0 not accepted meanwhile.
    set_req(1'b1, 32'hAAAA5555, 32'h12345678, 3'b011);
    expect_ready(1'b0, 1'b1, "bp_acc");
    @(negedge clk);
    clr_req(1'b1);
    set_req(1'b0, 32'd100, 32'd23, 3'b000);
    expect_ready(1'b0, 1'b0, "bp_exec");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_hold_vld", {31'b0, bus.resp_valid}, 32'd1);
      check("bp_hold_res", bus.resp_result, 32'hB89E032D);
      check("bp_hold_id", {31'b0, bus.resp_id}, 32'd1);
      check("bp_hold_rdy0", {31'b0, bus.req0_ready}, 32'd0);
    end
    @(negedge clk);
    resp_check("bp_r", 32'hB89E032D, 1'b1, 1'b0);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    expect_ready(1'b1, 1'b0, "bp_after");
    check("bp_after_vld", {31'b0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    clr_req(1'b0);
    @(negedge clk);
    resp_check("bp_r0", 32'd123, 1'b0, 1'b0);
    @(negedge clk);
    bus.resp_ready = 1'b0;

    // Reset while in EXEC drops the transaction.
    set_req(1'b0, 32'd7, 32'd7, 3'b000);
    expect_ready(1'b1, 1'b0, "mr_acc");
    @(negedge clk);
    clr_req(1'b0);
    #1;
    check("mr_exec_alu_a", bus.alu_a, 32'd7);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("mr");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("mr_no_resp", {31'b0, bus.resp_valid}, 32'd0);
    end
    @(negedge clk);
    set_req(1'b0, 32'd2, 32'd3, 3'b000);
    set_req(1'b1, 32'd9, 32'd4, 3'b001);
    expect_ready(1'b1, 1'b0, "mr_cont");
    @(negedge clk);
    clr_req(1'b0);
    @(negedge clk);
    resp_check("mr_r0", 32'd5, 1'b0, 1'b0);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    expect_ready(1'b0, 1'b1, "mr_cont2");
    @(negedge clk);
    clr_req(1'b1);
    @(negedge clk);
    resp_check("mr_r1", 32'd5, 1'b1, 1'b0);
    @(negedge clk);
    bus.resp_ready = 1'b0;

    // req1 streaming alone with resp_ready held high: one accept every 3 cycles.
    bus.resp_ready = 1'b1;
    set_req(1'b1, 32'd1, 32'd10, 3'b000);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      #1;
      while (!bus.req1_ready && n < 10) begin
        @(negedge clk); #1;
        n++;
      end
      check("st_wait", n, 32'd0);
      t_acc[i] = cyc;
      @(negedge clk);
      if (i < 2) set_req(1'b1, i + 2, 32'd10, 3'b000);
      else       clr_req(1'b1);
      #1;
      check("st_exec_vld", {31'b0, bus.resp_valid}, 32'd0);
      @(negedge clk);
      #1;
      check("st_vld", {31'b0, bus.resp_valid}, 32'd1);
      check("st_res", bus.resp_result, i + 11);
      check("st_id", {31'b0, bus.resp_id}, 32'd1);
      @(negedge clk);
    end
    check("st_gap01", t_acc[1] - t_acc[0], 32'd3);
    check("st_gap12", t_acc[2] - t_acc[1], 32'd3);
    bus.resp_ready = 1'b0;

    // After req1 won last, contention must favour req0.
    set_req(1'b0, 32'd1, 32'd1, 3'b000);
    set_req(1'b1, 32'd1, 32'd1, 3'b000);
    expect_ready(1'b1, 1'b0, "st_cont");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
